// File: rtl/rv_plic_gw_pkg.sv
// Shared types for the PLIC interrupt gateway: per-source state encoding and defaults.
package rv_plic_gw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PEND   = 2'b01,
        ACTIVE = 2'b10
    } gw_state_e;

    localparam int unsigned CntWDefault = 2;

endpackage

// File: rtl/rv_plic_gw_src.sv
// One gateway source: edge detect, IDLE/PEND/ACTIVE sequencing, queued-edge counter, sticky overflow.
module rv_plic_gw_src
    import rv_plic_gw_pkg::*;
#(
    parameter int unsigned CntW = CntWDefault
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    input  logic le_i,
    input  logic claim_i,
    input  logic complete_i,
    input  logic ovf_clr_i,
    output logic ip_o,
    output logic active_o,
    output logic ovf_o
);

    localparam logic [CntW-1:0] CntMax = '1;

    gw_state_e       state, state_d;
    logic [CntW-1:0] cnt, cnt_d;
    logic            src_q;
    logic            ovf_d;
    logic            edge_det;
    logic            bump;

    assign edge_det = src_i & ~src_q;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ovf_d   = ovf_o & ~ovf_clr_i;
        bump    = 1'b0;
        case (state)
            IDLE: begin
                if (le_i) begin
                    if (edge_det || cnt != '0) state_d = PEND;
                    // A fresh edge is consumed directly; the queue only drains when no edge arrived.
                    if (!edge_det && cnt != '0) cnt_d = cnt - 1'b1;
                end else if (src_i) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (claim_i) state_d = ACTIVE;
                bump = le_i & edge_det;
            end
            ACTIVE: begin
                if (complete_i) state_d = IDLE;
                bump = le_i & edge_det;
            end
            default: state_d = IDLE;
        endcase
        // Set beats clear: ovf_d already has the clear folded in.
        if (bump) begin
            if (cnt != CntMax) cnt_d = cnt + 1'b1;
            else               ovf_d = 1'b1;
        end
        if (!le_i) cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            src_q    <= 1'b0;
            ip_o     <= 1'b0;
            active_o <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            src_q    <= src_i;
            ip_o     <= (state_d == PEND);
            active_o <= (state_d == ACTIVE);
            ovf_o    <= ovf_d;
        end
    end

endmodule

// File: rtl/rv_plic_gateway.sv
// PLIC gateway bank: one independent rv_plic_gw_src per interrupt source.
module rv_plic_gateway
    import rv_plic_gw_pkg::*;
#(
    parameter int unsigned NumSrc = 32,
    parameter int unsigned CntW   = CntWDefault
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumSrc-1:0] src_i,
    input  logic [NumSrc-1:0] le_i,
    input  logic [NumSrc-1:0] claim_i,
    input  logic [NumSrc-1:0] complete_i,
    input  logic [NumSrc-1:0] ovf_clr_i,
    output logic [NumSrc-1:0] ip_o,
    output logic [NumSrc-1:0] active_o,
    output logic [NumSrc-1:0] ovf_o
);

    for (genvar i = 0; i < NumSrc; i++) begin : g_src
        rv_plic_gw_src #(
            .CntW(CntW)
        ) u_src (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .src_i     (src_i[i]),
            .le_i      (le_i[i]),
            .claim_i   (claim_i[i]),
            .complete_i(complete_i[i]),
            .ovf_clr_i (ovf_clr_i[i]),
            .ip_o      (ip_o[i]),
            .active_o  (active_o[i]),
            .ovf_o     (ovf_o[i])
        );
    end

endmodule
